// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first bit-serial adder, one full-adder slice per clock.
// Optional signed overflow output enabled by defining BIT_SERIAL_ADDER_OVF_EN.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_sum;
  logic [CW-1:0] r_count;
  logic r_carry, r_cout;
  logic w_s, w_c, w_last;
  logic [WIDTH-1:0] w_res_next;
  assign w_s = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last = r_count == LAST;
  assign w_res_next = {w_s, r_res[WIDTH-1:1]};
  assign busy = r_state == S_SHIFT;
  assign done = r_state == S_DONE;
  assign sum = r_sum;
  assign cout = r_cout;
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE)  ? (start  ? S_SHIFT : S_IDLE) :
             (r_state == S_SHIFT) ? (w_last ? S_DONE  : S_SHIFT) : S_IDLE;
  end
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;
  // r_carry on the last shift is the carry into the MSB
  always_ff @(posedge clk)
    if (rst) r_ovf <= 1'b0;
    else if (r_state == S_SHIFT && w_last) r_ovf <= r_carry ^ w_c;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_count <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_a     <= a_in;
      r_b     <= b_in;
      r_carry <= cin;
      r_count <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_c;
      r_count <= r_count + CW'(1);
      r_res   <= w_res_next;
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_c;
      end
    end
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed and random checks of the 8-bit serial adder.
module tb_bit_serial_adder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic busy, done, cout;
  logic [7:0] sum;
  int checks = 0, errors = 0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic ovf;
`endif
  bit_serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef BIT_SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  // Launches one add and returns at the negedge of the done cycle (or on timeout).
  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output int bcnt);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_in = 8'hXX; b_in = 8'hXX; cin = 1'bx;
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, cout, sum} !== 11'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
    end
`ifdef BIT_SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    rst = 1'b0;
  endtask
  task automatic test_basic;
    int lat, bc;
    do_add(8'h0F, 8'h01, 1'b0, lat, bc);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", lat); end
    checks++;
    if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
    checks++;
    if ({cout, sum} !== 9'h010) begin errors++; $display("FAIL basic_sum: got %b_%h want 0_10", cout, sum); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: done=%b after one cycle, want 0", done); end
  endtask
  task automatic test_carry;
    int lat, bc;
    do_add(8'hFF, 8'h01, 1'b0, lat, bc);
    checks++;
    if ({cout, sum} !== 9'h100) begin errors++; $display("FAIL carry_wrap: got %b_%h want 1_00", cout, sum); end
    do_add(8'h00, 8'h00, 1'b1, lat, bc);
    checks++;
    if ({cout, sum} !== 9'h001) begin errors++; $display("FAIL carry_in: got %b_%h want 0_01", cout, sum); end
    do_add(8'hFF, 8'hFF, 1'b1, lat, bc);
    checks++;
    if ({cout, sum} !== 9'h1FF) begin errors++; $display("FAIL carry_max: got %b_%h want 1_ff", cout, sum); end
  endtask
  task automatic test_start_ignored;
    int lat, dones;
    @(negedge clk);
    a_in = 8'h03; b_in = 8'h04; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a_in = 8'h55; b_in = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL ignore_latency: got %0d want 9", lat); end
    checks++;
    if ({cout, sum} !== 9'h007) begin errors++; $display("FAIL ignore_sum: got %b_%h want 0_07", cout, sum); end
    start = 1'b1;  // start during DONE must also be dropped
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL ignore_no_second_op: got %0d active cycles want 0", dones); end
    checks++;
    if ({cout, sum} !== 9'h007) begin errors++; $display("FAIL ignore_sum_held: got %b_%h want 0_07", cout, sum); end
  endtask
  task automatic test_mid_reset;
    int lat, bc, dones;
    @(negedge clk);
    a_in = 8'hF0; b_in = 8'h0F; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, cout, sum} !== 11'h0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles want 0", dones); end
    do_add(8'h10, 8'h20, 1'b0, lat, bc);
    checks++;
    if ({cout, sum} !== 9'h030 || lat !== 9) begin
      errors++;
      $display("FAIL midrst_recover: got %b_%h lat %0d want 0_30 lat 9", cout, sum, lat);
    end
  endtask
  task automatic test_hold;
    int lat, bc, bad;
    do_add(8'h50, 8'h55, 1'b0, lat, bc);
    checks++;
    if ({cout, sum} !== 9'h0A5) begin errors++; $display("FAIL hold_sum: got %b_%h want 0_a5", cout, sum); end
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if ({cout, sum} !== 9'h0A5 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
    do_add(8'h01, 8'h01, 1'b0, lat, bc);
    checks++;
    if ({cout, sum} !== 9'h002) begin errors++; $display("FAIL hold_next_update: got %b_%h want 0_02", cout, sum); end
  endtask
`ifdef BIT_SERIAL_ADDER_OVF_EN
  task automatic test_ovf;
    int lat, bc;
    do_add(8'h7F, 8'h01, 1'b0, lat, bc);
    checks++;
    if ({ovf, cout, sum} !== 10'b10_1000_0000) begin
      errors++;
      $display("FAIL ovf_pos: got ovf=%b cout=%b sum=%h want 1 0 80", ovf, cout, sum);
    end
    do_add(8'hFF, 8'h01, 1'b0, lat, bc);
    checks++;
    if ({ovf, cout, sum} !== 10'b01_0000_0000) begin
      errors++;
      $display("FAIL ovf_none: got ovf=%b cout=%b sum=%h want 0 1 00", ovf, cout, sum);
    end
    do_add(8'h80, 8'h80, 1'b0, lat, bc);
    checks++;
    if ({ovf, cout, sum} !== 10'b11_0000_0000) begin
      errors++;
      $display("FAIL ovf_neg: got ovf=%b cout=%b sum=%h want 1 1 00", ovf, cout, sum);
    end
  endtask
`endif
  task automatic test_random;
    int lat, bc, bad;
    logic [7:0] a, b;
    logic c;
    logic [8:0] exp;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + {8'h0, c};
      do_add(a, b, c, lat, bc);
      checks++;
      if ({cout, sum} !== exp || lat !== 9) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL random_%0d: %h+%h+%b got %b_%h lat %0d want %b_%h lat 9",
                               i, a, b, c, cout, sum, lat, exp[8], exp[7:0]);
      end
`ifdef BIT_SERIAL_ADDER_OVF_EN
      checks++;
      if (ovf !== ((a[7] == b[7]) && (exp[7] != a[7]))) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL random_ovf_%0d: %h+%h+%b got %b want %b",
                               i, a, b, c, ovf, (a[7] == b[7]) && (exp[7] != a[7]));
      end
`endif
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_start_ignored;
    test_mid_reset;
    test_hold;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    test_ovf;
`endif
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
